// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock through a
// single shared SubWord lane, with the full schedule held for round-key reads.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expand_iter #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  localparam int NW_MAX = ENABLE_256 ? 60 : (ENABLE_192 ? 52 : 44);
  localparam logic [5:0] NW_MAX_W = 6'(NW_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [5:0]   nw_q, nw_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         kv_q, kv_d;
  logic [31:0]  w_q [NW_MAX];
  logic [31:0]  w_d [NW_MAX];

  logic         mode_ok;
  logic [5:0]   idx_prev, idx_back;
  logic [31:0]  prev_word, back_word;
  logic [31:0]  sub_in, sub_out, t_word, new_word;

  assign mode_ok = (key_len == 2'd0) || (key_len == 2'd1 && ENABLE_192) ||
                   (key_len == 2'd2 && ENABLE_256);

  // Operand fetch for w[i]: w[i-1] feeds the S-box lane, w[i-Nk] is the XOR partner.
  always_comb begin
    idx_prev  = i_q - 6'd1;
    idx_back  = i_q - {2'b00, nk_q};
    prev_word = (idx_prev < NW_MAX_W) ? w_q[idx_prev] : 32'h0;
    back_word = (idx_back < NW_MAX_W) ? w_q[idx_back] : 32'h0;
    sub_in    = (cnt_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sub_in[8*gi +: 8]),
        .out_byte (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  // cnt_q == 0 marks i mod Nk == 0; for Nk = 8, cnt_q == 4 marks i mod 8 == 4.
  always_comb begin
    if (cnt_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && cnt_q == 3'd4) begin
      t_word = sub_out;
    end else begin
      t_word = prev_word;
    end
    new_word = back_word ^ t_word;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    nw_d    = nw_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    w_d     = w_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kv_d = 1'b0;
          if (mode_ok) begin
            state_d = ST_LOAD;
            key_d   = key_in;
            busy_d  = 1'b1;
            case (key_len)
              2'd1:    begin nk_d = 4'd6; nr_d = 4'd12; nw_d = 6'd52; end
              2'd2:    begin nk_d = 4'd8; nr_d = 4'd14; nw_d = 6'd60; end
              default: begin nk_d = 4'd4; nr_d = 4'd10; nw_d = 6'd44; end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) < nk_q) w_d[k] = key_q[255-32*k -: 32];
        end
        i_d     = {2'b00, nk_q};
        cnt_d   = 3'd0;
        rcon_d  = 8'h01;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (i_q < NW_MAX_W) w_d[i_q] = new_word;
        if (cnt_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (i_q == nw_q - 6'd1) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          kv_d    = 1'b1;
        end else begin
          i_d   = i_q + 6'd1;
          cnt_d = (cnt_q == 3'd0) ? 3'(nk_q - 4'd1) : cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      nk_q    <= 4'd4;
      nr_q    <= 4'd0;
      nw_q    <= 6'd44;
      i_q     <= 6'd0;
      cnt_q   <= 3'd0;
      rcon_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      w_q     <= '{default: 32'h0};
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      nw_q    <= nw_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      w_q     <= w_d;
    end
  end

  logic [5:0]  rk_base;
  logic [5:0]  rk_widx [4];
  logic [31:0] rk_word [4];

  always_comb begin
    rk_base = {rk_idx, 2'b00};
    for (int k = 0; k < 4; k++) begin
      rk_widx[k] = rk_base + 6'(k);
      rk_word[k] = (rk_widx[k] < NW_MAX_W) ? w_q[rk_widx[k]] : 32'h0;
    end
    rk_out = '0;
    if (kv_q && rk_idx <= nr_q) rk_out = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = kv_q;
endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Directed bench for aes_key_expand_iter using FIPS-197 key expansion vectors.

module tb_aes_key_expand_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic         busy, done, err, keys_valid;
  logic [127:0] rk_out;
  logic         busy2, done2, err2, keys_valid2;
  logic [127:0] rk_out2;

  int tests = 0;
  int fails = 0;
  int lat;
  logic seen_done;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KB   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  always #5 clk = ~clk;

  aes_key_expand_iter u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_expand_iter #(.ENABLE_192(1'b1), .ENABLE_256(1'b0)) u_dut_no256 (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy2), .done(done2), .err(err2), .keys_valid(keys_valid2),
    .rk_idx(rk_idx), .rk_out(rk_out2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    start = 1'b1; key_len = kl; key_in = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat counts the edge after acceptance at which done is sampled high.
  task automatic wait_done(input int lat0, output int lat_o);
    lat_o = lat0;
    while (lat_o < 300) begin
      @(negedge clk);
      lat_o++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic chk_rk(input int idx, input logic [127:0] exp, input string tag);
    rk_idx = 4'(idx);
    #1 check(tag, rk_out, exp);
  endtask

  task automatic chk_rk_lo(input int idx, input logic [31:0] exp, input string tag);
    rk_idx = 4'(idx);
    #1 check(tag, {96'h0, rk_out[31:0]}, {96'h0, exp});
  endtask

  task automatic chk_rk_hi(input int idx, input logic [31:0] exp, input string tag);
    rk_idx = 4'(idx);
    #1 check(tag, {96'h0, rk_out[127:96]}, {96'h0, exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_flags", {124'h0, busy, done, err, keys_valid}, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rk_out", rk_out, 128'h0);

    // AES-128
    kick(2'd0, K128);
    @(negedge clk);
    $display("[TB] aes128 start");
    check("a128_busy", {127'h0, busy}, 128'h1);
    wait_done(1, lat);
    check("a128_lat", 128'(lat), 128'd42);
    check("a128_busy_at_done", {126'h0, busy, keys_valid}, 128'h1);
    chk_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_rk10");
    chk_rk(1, 128'ha0fafe1788542cb123a339392a6c7605, "a128_rk1");
    chk_rk(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "a128_rk0");
    chk_rk(11, 128'h0, "a128_rk11_zero");
    @(negedge clk);
    check("a128_done_pulse", {127'h0, done}, 128'h0);

    // AES-192
    kick(2'd1, K192);
    @(negedge clk);
    $display("[TB] aes192 start");
    wait_done(1, lat);
    check("a192_lat", 128'(lat), 128'd48);
    chk_rk_lo(12, 32'h01002202, "a192_w51");
    chk_rk(13, 128'h0, "a192_rk13_zero");
    chk_rk(0, 128'h8e73b0f7da0e6452c810f32b809079e5, "a192_rk0");
    chk_rk_hi(1, 32'h62f8ead2, "a192_w4");

    // AES-256 (the no-256 instance must reject it)
    kick(2'd2, K256);
    @(negedge clk);
    $display("[TB] aes256 start");
    check("no256_err", {125'h0, err2, busy2, keys_valid2}, 128'h4);
    wait_done(1, lat);
    check("a256_lat", 128'(lat), 128'd54);
    chk_rk_lo(14, 32'h706c631e, "a256_w59");
    chk_rk_hi(2, 32'h9ba35411, "a256_w8");
    chk_rk_hi(3, 32'ha8b09c1a, "a256_w12");
    chk_rk(0, 128'h603deb1015ca71be2b73aef0857d7781, "a256_rk0");

    // Invalid key_len
    kick(2'd3, K128);
    @(negedge clk);
    $display("[TB] invalid key_len");
    check("inv_err", {125'h0, err, busy, keys_valid}, 128'h4);
    chk_rk(0, 128'h0, "inv_rk_zero");
    @(negedge clk);
    check("inv_err_pulse", {127'h0, err}, 128'h0);

    // start re-pulsed mid-EXPAND with another mode and key
    kick(2'd0, K128);
    lat = 0;
    repeat (10) begin @(negedge clk); lat++; end
    start = 1'b1; key_len = 2'd2; key_in = K256;
    @(negedge clk); lat++;
    start = 1'b0;
    $display("[TB] restart ignored");
    wait_done(lat, lat);
    check("restart_lat", 128'(lat), 128'd42);
    chk_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_rk10");

    // Reset mid-expansion
    kick(2'd2, K256);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("[TB] reset mid-expansion");
    check("midrst_flags", {124'h0, busy, done, err, keys_valid}, 128'h0);
    rk_idx = 4'd0;
    #1 check("midrst_rk", rk_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("midrst_no_done", {127'h0, seen_done}, 128'h0);
    kick(2'd0, K128);
    @(negedge clk);
    wait_done(1, lat);
    check("postrst_lat", 128'(lat), 128'd42);
    chk_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "postrst_rk10");

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; key_in = K128;
    @(posedge clk);
    $display("[TB] back-to-back");
    wait_done(0, lat);
    check("b2b_lat1", 128'(lat), 128'd42);
    key_in = KB;
    @(negedge clk);
    check("b2b_idle_gap", {126'h0, busy, keys_valid}, 128'h1);
    chk_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "b2b_rk10_first");
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", {126'h0, busy, keys_valid}, 128'h2);
    wait_done(1, lat);
    check("b2b_lat2", 128'(lat), 128'd42);
    chk_rk(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "b2b_rk10_second");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
